// File: rtl/hack_mem_responder.sv
`default_nettype none
// ============================================================================
// hack_mem_responder : Hack data-memory responder (RAM, screen shadow, KBD)
//                      with a valid/ready FIFO forwarding screen writes.
// Revision 1.0
// ============================================================================
module hack_mem_responder #(
  parameter int RAM_AW     = 14,
  parameter int SCR_AW     = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  input  logic        kbd_valid,
  input  logic [15:0] kbd_code,
  output logic        scr_valid,
  output logic [12:0] scr_addr,
  output logic [15:0] scr_data,
  input  logic        scr_ready,
  output logic        scr_overflow
);

  localparam int              C_PW   = $clog2(FIFO_DEPTH);
  localparam int              C_CW   = C_PW + 1;
  localparam logic [C_CW-1:0] C_FULL = C_CW'(FIFO_DEPTH);

  logic [15:0] ram_mem  [2**RAM_AW];
  logic [15:0] scr_mem  [2**SCR_AW];
  logic [12:0] fifo_adr [FIFO_DEPTH];
  logic [15:0] fifo_dat [FIFO_DEPTH];

  logic [15:0]     kbd_q,   kbd_d;
  logic [C_PW-1:0] wptr_q,  wptr_d;
  logic [C_PW-1:0] rptr_q,  rptr_d;
  logic [C_CW-1:0] count_q, count_d;
  logic            ovf_q,   ovf_d;

  logic [14:0] a;
  logic        unused_addr_msb;
  logic        is_ram, is_scr, is_kbd;
  logic        ram_we, scr_we, push, pop, full, accept;

  assign a               = addressM[14:0];
  assign unused_addr_msb = addressM[15];
  assign is_ram          = ~a[14];
  assign is_scr          = (a[14:13] == 2'b10);
  assign is_kbd          = (a == 15'h6000);

  // Write strobes are qualified by reset level so a held-low reset blocks memory updates too.
  assign ram_we = reset & writeM & is_ram;
  assign scr_we = reset & writeM & is_scr;

  always_comb begin
    inM = 16'h0000;
    if (is_ram)      inM = ram_mem[a[RAM_AW-1:0]];
    else if (is_scr) inM = scr_mem[a[SCR_AW-1:0]];
    else if (is_kbd) inM = kbd_q;
  end

  assign scr_valid    = (count_q != '0);
  assign scr_addr     = fifo_adr[rptr_q];
  assign scr_data     = fifo_dat[rptr_q];
  assign scr_overflow = ovf_q;

  assign push   = scr_we;
  assign pop    = scr_valid & scr_ready;
  assign full   = (count_q == C_FULL);
  // A pop in the same edge frees the slot, so a full FIFO can still take the push.
  assign accept = push & (~full | pop);

  always_comb begin
    kbd_d   = kbd_valid ? kbd_code : kbd_q;
    wptr_d  = accept ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
    ovf_d   = ovf_q | (push & full & ~pop);
    count_d = count_q;
    if (accept && !pop)      count_d = count_q + 1'b1;
    else if (!accept && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kbd_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      kbd_q   <= kbd_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage arrays are never reset; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (ram_we) ram_mem[a[RAM_AW-1:0]] <= outM;
    if (scr_we) scr_mem[a[SCR_AW-1:0]] <= outM;
    if (accept) begin
      fifo_adr[wptr_q] <= a[12:0];
      fifo_dat[wptr_q] <= outM;
    end
  end

endmodule
`default_nettype wire

// File: doc/hack_mem_responder.md
Name: hack_mem_responder

Overview:
- Responder side of the CPU data-memory bus (addressM/outM/writeM in, inM out).
- Decodes the Hack memory map into RAM, a screen shadow memory and the keyboard register.
- Returns read data to the CPU in the same cycle, so the single-cycle CPU needs no wait states.
- Forwards every screen write to a downstream display engine through a small valid/ready FIFO.

Parameters:
- RAM_AW, 14: RAM address width; 2**RAM_AW words at 0x0000.
- SCR_AW, 13: screen address width; 8192 words at 0x4000.
- FIFO_DEPTH, 4: screen-write FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- addressM  in  16  CPU data address; only bits [14:0] are decoded, bit 15 is ignored.
- outM  in  16  CPU write data.
- writeM  in  1  CPU write strobe for the current cycle.
- inM  out  16  read data to the CPU; combinational from addressM.
- kbd_valid  in  1  single-cycle strobe, new key code available.
- kbd_code  in  16  key code; 0 means no key pressed.
- scr_valid  out  1  FIFO head valid.
- scr_addr  out  13  screen word offset of the FIFO head.
- scr_data  out  16  pixel word of the FIFO head.
- scr_ready  in  1  display engine accepts the head this cycle.
- scr_overflow  out  1  sticky flag: a screen write was dropped.

Behaviour:
- Decode on A = addressM[14:0]:
  - 0x0000..0x3FFF: RAM.
  - 0x4000..0x5FFF: screen shadow.
  - 0x6000: KBD.
  - 0x6001..0x7FFF: unmapped.
- Reads: inM = word at A, combinational, no latency. Unmapped reads return 0x0000. KBD reads return kbd_reg.
- Writes: when writeM=1, the word is written on the rising edge.
  - A read of the same address in the same cycle returns the old value; the next cycle returns the new value.
  - Writes to KBD or unmapped addresses are ignored: no state change, no FIFO push.
- Screen write: updates the shadow word and pushes {A[12:0], outM} into the FIFO in the same edge.
- FIFO:
  - scr_valid = (count != 0); the head is driven directly from storage.
  - Pop when scr_valid && scr_ready.
  - Entries leave in write order. Two writes to the same screen address produce two entries; no merging.
  - Push while full with no pop: entry dropped, shadow still updated, scr_overflow set to 1 until reset.
  - Push while full with a pop in the same cycle: push accepted, count unchanged, no overflow.
  - Push and pop in the same cycle when not full: count unchanged.
  - scr_ready while empty: no effect.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - scr_addr/scr_data hold stable while scr_valid=1 and scr_ready=0.
- Keyboard: kbd_reg <= kbd_code on any clk edge with kbd_valid=1, otherwise it holds; a code of 0 clears it.
- Reset asserted (low), asynchronously:
  - kbd_reg=0, FIFO empty (pointers and count 0), scr_valid=0, scr_overflow=0.
  - Pending FIFO entries are discarded.
  - RAM and shadow contents are not reset and are left unchanged.
  - While reset is low, writeM and kbd_valid are ignored; inM still reflects memory.
- Reset deasserted: the first write is accepted on the first rising edge with reset high.

Test Plan:
- RAM: write 0x1234 to 0x0010, reading 0x0010 in the same cycle -> old value; next cycle inM=0x1234. A write of 0xFFFF to 0x3FFF reads back 0xFFFF.
- Screen: write 0xA5A5 to 0x4001 with scr_ready=0 -> next cycle scr_valid=1, scr_addr=0x0001, scr_data=0xA5A5, and a read of 0x4001 returns 0xA5A5. Raise scr_ready for 1 cycle -> scr_valid=0.
- Overflow: with scr_ready=0, 5 screen writes (0x4000..0x4004, data 1..5) -> FIFO holds 1..4 and scr_overflow=1. Draining pops addr 0..3 in order, then scr_valid=0, and reading 0x4004 still returns 5.
- Full with simultaneous push+pop: FIFO full, write 0x4007 with scr_ready=1 -> no overflow, count stays 4, entry 0x0007 is the last to drain.
- Keyboard/unmapped: kbd_valid with code 0x0041 -> 0x6000 reads 0x0041. CPU writes 0x9999 to 0x6000 -> still 0x0041. Code 0 -> reads 0. 0x7000 reads 0; a write to 0x7000 pushes nothing.
- Reset mid-operation: 3 entries queued, overflow set, reset low for half a cycle -> immediately scr_valid=0, scr_overflow=0, 0x6000 reads 0, RAM 0x0010 still 0x1234.
